// File: rtl/emds_serial_rx.sv
// EMDS receive stage: deframes the 1-bit serial line into bytes and packs them into a message buffer.
// Optional build macro EMDS_RX_PARITY_EN adds an even-parity bit per frame and the parity_error output.
module emds_serial_rx #(
   parameter int MSG_CHARS    = 100,
   parameter int CLKS_PER_BIT = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in,
   output logic [8*MSG_CHARS:1] message,
   output logic                 message_valid,
   output logic [7:0]           char_count,
   output logic                 busy,
   output logic                 frame_error
`ifdef EMDS_RX_PARITY_EN
   ,
   output logic                 parity_error
`endif
);

   localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [PW-1:0] SAMPLE_PH = PW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [PW-1:0] LAST_PH   = PW'(CLKS_PER_BIT - 1);
   localparam logic [7:0]    FULL_CNT  = 8'(MSG_CHARS);
`ifdef EMDS_RX_PARITY_EN
   localparam logic [3:0]    LAST_BIT  = 4'd8;
`else
   localparam logic [3:0]    LAST_BIT  = 4'd7;
`endif

   if (MSG_CHARS < 1 || MSG_CHARS > 255) begin : g_bad_msg_chars
      $error("emds_serial_rx: MSG_CHARS must be in 1..255");
   end
   if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
      $error("emds_serial_rx: CLKS_PER_BIT must be >= 1");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

   state_t                 state_q, state_d;
   logic [PW-1:0]          phase_q, phase_d;
   logic [3:0]             bit_q, bit_d;
   logic [7:0]             shift_q, shift_d;
   logic [8*MSG_CHARS-1:0] msg_q, msg_d, base_msg;
   logic [7:0]             cnt_q, cnt_d, base_cnt;
   logic                   done_q, done_d;
   logic                   valid_q, valid_d;
   logic                   ferr_q, ferr_d;
   logic                   at_sample, at_last, shift_en, stop_smp;
   logic                   par_ok, accept, is_term, store;
`ifdef EMDS_RX_PARITY_EN
   logic                   par_q, par_d, perr_q, perr_d, par_en;
`endif

   assign at_sample = (phase_q == SAMPLE_PH);
   assign at_last   = (phase_q == LAST_PH);

   always_ff @(posedge clock) begin : state_reg
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // The IDLE cycle that sees the line low already counts as phase 0 of the start bit.
   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (!in) state_d = (CLKS_PER_BIT == 1) ? S_DATA : S_START;
         S_START:     if (at_sample && in) state_d = S_IDLE;
                      else if (at_last) state_d = S_DATA;
         S_DATA:      if (at_last && bit_q == LAST_BIT) state_d = S_STOP;
         S_STOP:      if (at_sample && !in) state_d = S_WAIT_HIGH;
                      else if (at_last) state_d = S_IDLE;
         S_WAIT_HIGH: if (in) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_comb begin : fsm_outputs
      busy     = (state_q != S_IDLE) || (cnt_q != 8'd0 && !done_q);
      shift_en = (state_q == S_DATA) && at_sample && (bit_q < 4'd8);
      stop_smp = (state_q == S_STOP) && at_sample;
`ifdef EMDS_RX_PARITY_EN
      par_en   = (state_q == S_DATA) && at_sample && (bit_q == 4'd8);
`endif
   end

   always_comb begin : bit_timing
      phase_d = '0;
      if (state_q == S_IDLE && state_d == S_START)
         phase_d = PW'(1);
      else if (state_d == state_q && !at_last &&
               (state_q == S_START || state_q == S_DATA || state_q == S_STOP))
         phase_d = phase_q + PW'(1);
      bit_d = bit_q;
      if (state_q == S_DATA && at_last)
         bit_d = (bit_q == LAST_BIT) ? 4'd0 : bit_q + 4'd1;
      shift_d = shift_en ? {shift_q[6:0], in} : shift_q;
`ifdef EMDS_RX_PARITY_EN
      par_d   = par_en ? in : par_q;
`endif
   end

`ifdef EMDS_RX_PARITY_EN
   assign par_ok = ~(^{shift_q, par_q});
   assign perr_d = stop_smp && in && !par_ok;
`else
   assign par_ok = 1'b1;
`endif
   assign ferr_d  = stop_smp && !in;
   assign accept  = stop_smp && in && par_ok;
   assign is_term = (shift_q == 8'h00) || (shift_q == 8'h0A);
   assign store   = accept && !is_term;

   // A completed message stays readable until the next accepted byte clears it.
   assign base_msg = (accept && done_q) ? '0 : msg_q;
   assign base_cnt = (accept && done_q) ? 8'd0 : cnt_q;

   for (genvar k = 0; k < MSG_CHARS; k++) begin : g_slot
      assign msg_d[8*(MSG_CHARS-1-k) +: 8] = (store && base_cnt == 8'(k)) ?
                                             shift_q : base_msg[8*(MSG_CHARS-1-k) +: 8];
   end

   always_comb begin : byte_ctrl
      cnt_d   = base_cnt;
      valid_d = 1'b0;
      done_d  = done_q;
      if (accept && is_term) begin
         valid_d = 1'b1;
         done_d  = 1'b1;
      end else if (store) begin
         cnt_d   = base_cnt + 8'd1;
         valid_d = (cnt_d == FULL_CNT);
         done_d  = valid_d;
      end
   end

   always_ff @(posedge clock) begin : datapath
      if (reset) begin
         phase_q <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         msg_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b1;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef EMDS_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         phase_q <= phase_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         msg_q   <= msg_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
`ifdef EMDS_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   assign message       = msg_q;
   assign char_count    = cnt_q;
   assign message_valid = valid_q;
   assign frame_error   = ferr_q;
`ifdef EMDS_RX_PARITY_EN
   assign parity_error  = perr_q;
`endif

endmodule

// File: tb/tb_emds_serial_rx.sv
// Directed bench for emds_serial_rx: one instance at 1 clock/bit, one at 4 clocks/bit.
module tb_emds_serial_rx;

   localparam int MSG = 100;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in1 = 1'b1;
   logic             in4 = 1'b1;
   logic [8*MSG:1]   message1, message4;
   logic             mv1, mv4, busy1, busy4, fe1, fe4;
   logic [7:0]       cc1, cc4;
`ifdef EMDS_RX_PARITY_EN
   logic             pe1, pe4;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int vcnt1 = 0, vcnt4 = 0, fecnt1 = 0, fecnt4 = 0;

   always #5 clk = ~clk;

   emds_serial_rx #(.MSG_CHARS(MSG), .CLKS_PER_BIT(1)) u1 (
      .clock(clk), .reset(rst), .in(in1), .message(message1), .message_valid(mv1),
      .char_count(cc1), .busy(busy1), .frame_error(fe1)
`ifdef EMDS_RX_PARITY_EN
      , .parity_error(pe1)
`endif
   );

   emds_serial_rx #(.MSG_CHARS(MSG), .CLKS_PER_BIT(4)) u4 (
      .clock(clk), .reset(rst), .in(in4), .message(message4), .message_valid(mv4),
      .char_count(cc4), .busy(busy4), .frame_error(fe4)
`ifdef EMDS_RX_PARITY_EN
      , .parity_error(pe4)
`endif
   );

   always @(negedge clk) begin
      if (mv1) vcnt1++;
      if (mv4) vcnt4++;
      if (fe1) fecnt1++;
      if (fe4) fecnt4++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   // Returns at #1 after the edge that samples the stop bit.
   task automatic send1(input logic [7:0] d, input logic stop, input logic par_bad);
      in1 = 1'b0;
      tick();
      for (int b = 7; b >= 0; b--) begin
         in1 = d[b];
         tick();
      end
`ifdef EMDS_RX_PARITY_EN
      in1 = (^d) ^ par_bad;
      tick();
`endif
      in1 = stop;
      tick();
   endtask

   // Each bit is correct only at phase 1 (and phase 0 of the start bit), so only the sample point sees it.
   task automatic send4(input logic [7:0] d);
      logic [10:0] fr;
      int          n;
`ifdef EMDS_RX_PARITY_EN
      fr = {1'b0, d, ^d, 1'b1};
      n  = 11;
`else
      fr = {1'b0, d, 1'b1, 1'b1};
      n  = 10;
`endif
      for (int k = 0; k < n; k++) begin
         for (int ph = 0; ph < 4; ph++) begin
            in4 = (ph == 1 || (k == 0 && ph == 0)) ? fr[10-k] : ~fr[10-k];
            tick();
         end
      end
      in4 = 1'b1;
   endtask

   typedef struct {
      logic [7:0]  dat;
      logic        stop;
      logic        lvl;
      int          gap;
      logic [7:0]  cc;
      logic        mv;
      logic        fe;
      logic        busy;
      logic [15:0] top;
   } vec_t;

   vec_t vt[11];
   int   vbase;

   initial begin
      vt[0]  = '{8'h48, 1'b1, 1'b1, 2, 8'd1, 1'b0, 1'b0, 1'b1, 16'h4800};
      vt[1]  = '{8'h69, 1'b1, 1'b1, 2, 8'd2, 1'b0, 1'b0, 1'b1, 16'h4869};
      vt[2]  = '{8'h0A, 1'b1, 1'b1, 2, 8'd2, 1'b1, 1'b0, 1'b0, 16'h4869};
      vt[3]  = '{8'h41, 1'b1, 1'b1, 0, 8'd1, 1'b0, 1'b0, 1'b1, 16'h4100};
      vt[4]  = '{8'h42, 1'b1, 1'b1, 0, 8'd2, 1'b0, 1'b0, 1'b1, 16'h4142};
      vt[5]  = '{8'h00, 1'b1, 1'b1, 0, 8'd2, 1'b1, 1'b0, 1'b0, 16'h4142};
      vt[6]  = '{8'h43, 1'b1, 1'b1, 0, 8'd1, 1'b0, 1'b0, 1'b1, 16'h4300};
      vt[7]  = '{8'h00, 1'b1, 1'b1, 2, 8'd1, 1'b1, 1'b0, 1'b0, 16'h4300};
      vt[8]  = '{8'h41, 1'b0, 1'b0, 5, 8'd1, 1'b0, 1'b1, 1'b1, 16'h4300};
      vt[9]  = '{8'h42, 1'b1, 1'b1, 2, 8'd1, 1'b0, 1'b0, 1'b1, 16'h4200};
      vt[10] = '{8'h0A, 1'b1, 1'b1, 2, 8'd1, 1'b1, 1'b0, 1'b0, 16'h4200};

      rst = 1'b1;
      repeat (3) tick();
      chk("rst_msg_zero", 32'(message1 == '0), 32'd1);
      chk("rst_valid", 32'(mv1), 32'd0);
      chk("rst_count", 32'(cc1), 32'd0);
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_ferr", 32'(fe1), 32'd0);
      chk("rst_count4", 32'(cc4), 32'd0);
      rst = 1'b0;
      tick();

      // Messages "Hi\n", "AB\0" + "C\0" back-to-back, bad stop bit, then "B\n".
      for (int i = 0; i < 11; i++) begin
         send1(vt[i].dat, vt[i].stop, 1'b0);
         chk($sformatf("v%0d_count", i), 32'(cc1), 32'(vt[i].cc));
         chk($sformatf("v%0d_valid", i), 32'(mv1), 32'(vt[i].mv));
         chk($sformatf("v%0d_ferr", i), 32'(fe1), 32'(vt[i].fe));
         chk($sformatf("v%0d_busy", i), 32'(busy1), 32'(vt[i].busy));
         chk($sformatf("v%0d_top", i), 32'(message1[8*MSG:8*MSG-15]), 32'(vt[i].top));
         chk($sformatf("v%0d_rest_zero", i), 32'(message1[8*MSG-16:1] == '0), 32'd1);
         in1 = vt[i].lvl;
         repeat (vt[i].gap) tick();
         if (!vt[i].lvl) begin
            chk($sformatf("v%0d_wait_high_busy", i), 32'(busy1), 32'd1);
            in1 = 1'b1;
            tick();
         end
         in1 = 1'b1;
      end
      repeat (2) tick();
      chk("valid_pulses", 32'(vcnt1), 32'd4);
      chk("ferr_pulses", 32'(fecnt1), 32'd1);

      // Buffer fill without terminator.
      vbase = vcnt1;
      for (int i = 0; i < 99; i++) send1(8'h7A, 1'b1, 1'b0);
      chk("full_cnt99", 32'(cc1), 32'd99);
      chk("full_valid99", 32'(mv1), 32'd0);
      send1(8'h7A, 1'b1, 1'b0);
      chk("full_valid100", 32'(mv1), 32'd1);
      chk("full_cnt100", 32'(cc1), 32'd100);
      chk("full_first", 32'(message1[8*MSG:8*MSG-7]), 32'h7A);
      chk("full_last", 32'(message1[8:1]), 32'h7A);
      send1(8'h71, 1'b1, 1'b0);
      chk("restart_cnt", 32'(cc1), 32'd1);
      chk("restart_first", 32'(message1[8*MSG:8*MSG-7]), 32'h71);
      chk("restart_slot1", 32'(message1[8*MSG-8:8*MSG-15]), 32'h00);
      chk("restart_valid", 32'(mv1), 32'd0);
      in1 = 1'b1;
      repeat (2) tick();
      chk("full_pulse_once", 32'(vcnt1 - vbase), 32'd1);

      // Four clocks per bit: glitch rejection, then sample-point check.
      in4 = 1'b0;
      tick();
      in4 = 1'b1;
      repeat (10) tick();
      chk("glitch_busy", 32'(busy4), 32'd0);
      chk("glitch_cnt", 32'(cc4), 32'd0);
      chk("glitch_ferr", 32'(fecnt4), 32'd0);
      send4(8'h78);
      repeat (4) tick();
      chk("cpb4_cnt", 32'(cc4), 32'd1);
      chk("cpb4_byte", 32'(message4[8*MSG:8*MSG-7]), 32'h78);
      chk("cpb4_ferr", 32'(fecnt4), 32'd0);
      chk("cpb4_valid", 32'(vcnt4), 32'd0);

      // Reset in the middle of 'K' with two chars buffered.
      send1(8'h72, 1'b1, 1'b0);
      chk("pre_rst_cnt", 32'(cc1), 32'd2);
      in1 = 1'b0;
      tick();
      for (int b = 7; b >= 5; b--) begin
         in1 = 8'h4B >> b;
         tick();
      end
      rst = 1'b1;
      in1 = 1'b1;
      tick();
      chk("midrst_msg_zero", 32'(message1 == '0), 32'd1);
      chk("midrst_cnt", 32'(cc1), 32'd0);
      chk("midrst_valid", 32'(mv1), 32'd0);
      chk("midrst_busy", 32'(busy1), 32'd0);
      chk("midrst_ferr", 32'(fe1), 32'd0);
      rst = 1'b0;
      tick();
      send1(8'h6F, 1'b1, 1'b0);
      send1(8'h6B, 1'b1, 1'b0);
      send1(8'h0A, 1'b1, 1'b0);
      chk("ok_cnt", 32'(cc1), 32'd2);
      chk("ok_valid", 32'(mv1), 32'd1);
      chk("ok_top", 32'(message1[8*MSG:8*MSG-15]), 32'h6F6B);
      in1 = 1'b1;
      repeat (2) tick();

`ifdef EMDS_RX_PARITY_EN
      send1(8'h41, 1'b1, 1'b1);
      chk("par_err", 32'(pe1), 32'd1);
      chk("par_ferr", 32'(fe1), 32'd0);
      chk("par_cnt", 32'(cc1), 32'd2);
      chk("par_valid", 32'(mv1), 32'd0);
      chk("par_top", 32'(message1[8*MSG:8*MSG-15]), 32'h6F6B);
      in1 = 1'b1;
      repeat (2) tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
